// File: rtl/vie_sram_resp.sv
// vie_sram_resp: responder end of the sram-like req/addr_ok/data_ok interface.
// Requests execute on an internal word RAM when accepted. Responses come back
// in order through a FIFO of QDEPTH entries after LAT cycles.
// Optional build macro VIE_RESP_STALL_EN adds LFSR-driven accept and response stalls.
module vie_sram_resp #(
  parameter int MEM_AW = 10,
  parameter int QDEPTH = 4,
  parameter int LAT    = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);
  localparam int PW  = $clog2(QDEPTH);
  localparam int CW  = PW + 1;
  localparam int AGW = $clog2(LAT + 1);

  logic [31:0]                mem [2**MEM_AW];
  logic [QDEPTH-1:0]          vld_q, vld_d;
  logic [QDEPTH-1:0][AGW-1:0] age_q, age_d;
  logic [QDEPTH-1:0][31:0]    dat_q, dat_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [MEM_AW-1:0]          widx;
  logic                       accept, pop, stall_acc, stall_rsp;

  // size is informational only; high and sub-word address bits are ignored
  logic unused_bits;
  assign unused_bits = ^{size, addr[31:MEM_AW+2], addr[1:0]};

`ifdef VIE_RESP_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;
  // Fibonacci LFSR, taps 16,14,13,11, steps every cycle
  always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  // LFSR state register
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) lfsr_q <= 16'hACE1;
    else         lfsr_q <= lfsr_d;
  assign stall_acc = (lfsr_q[1:0] == 2'b00);
  assign stall_rsp = (lfsr_q[3:2] == 2'b00);
`else
  assign stall_acc = 1'b0;
  assign stall_rsp = 1'b0;
`endif

  assign widx    = addr[MEM_AW+1:2];
  // No full-bypass: a pop this cycle does not free a slot until next cycle
  assign addr_ok = resetn & (cnt_q < CW'(QDEPTH)) & ~stall_acc;
  assign accept  = req & addr_ok;
  // Head age saturates at LAT, so a response stall simply holds it there
  assign data_ok = vld_q[rd_ptr_q] & (age_q[rd_ptr_q] == AGW'(LAT)) & ~stall_rsp;
  assign pop     = data_ok;
  assign rdata   = data_ok ? dat_q[rd_ptr_q] : 32'h0;

  // RAM write port: byte-masked write on an accepted write request (contents not reset)
  always_ff @(posedge clk)
    if (accept && wr)
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];

  // Response FIFO next state: age all entries, pop head, push new entry
  always_comb begin
    vld_d    = vld_q;
    age_d    = age_q;
    dat_d    = dat_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q + CW'(accept) - CW'(pop);
    for (int i = 0; i < QDEPTH; i++)
      if (vld_q[i] && age_q[i] != AGW'(LAT)) age_d[i] = age_q[i] + AGW'(1);
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PW'(1);
    end
    if (accept) begin
      // The acceptance cycle itself counts as age 0, so the entry becomes
      // visible with one cycle already elapsed: accept at t -> data_ok at t+LAT.
      vld_d[wr_ptr_q] = 1'b1;
      age_d[wr_ptr_q] = AGW'(1);
      dat_d[wr_ptr_q] = wr ? 32'h0 : mem[widx];
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
  end

  // Response FIFO state registers; reset drops everything in flight
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      vld_q    <= '0;
      age_q    <= '0;
      dat_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      vld_q    <= vld_d;
      age_q    <= age_d;
      dat_q    <= dat_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
endmodule
